hazard_stall_ctrl: RTL and testbench

//  Decode-stage hazard controller that drives the stall input of the ID/EX pipeline register.

---
 rtl/hazard_stall_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Decode-stage hazard controller. It detects a load-use hazard between the
//   load in EX and the instruction in decode, and drives the ID/EX bubble
//   (stall), the PC and IF/ID write enables, and the IF/ID squash on a branch
//   taken in decode. A slow data memory stretches each load-use stall to
//   1+MEM_WAIT cycles. Saturating counters track stall and flush cycles.
//
// Parameters
//   REG_W     register-index width
//   MEM_WAIT  extra load-latency cycles beyond 1 (0..15)
//   CNT_W     width of stallCount / flushCount
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   asynchronous, active-low reset
//   MemReadEnExecute  in   instruction in EX is a load
//   rtExecute         in   load destination register in EX
//   rsDecode          in   decode source register rs
//   rtDecode          in   decode source register rt
//   useRsDecode       in   decode instruction reads rs
//   useRtDecode       in   decode instruction reads rt
//   branchTakenD      in   branch in decode resolved taken this cycle
//   stall             out  to ID/EX: insert bubble at next edge
//   pcWriteEn         out  PC update enable
//   ifIdWriteEn       out  IF/ID load enable
//   ifIdFlush         out  IF/ID clear (squash fetched instruction)
//   stallCount        out  saturating count of cycles with stall=1
//   flushCount        out  saturating count of cycles with ifIdFlush=1
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadEnExecute,
    input  logic [REG_W-1:0] rtExecute,
    input  logic [REG_W-1:0] rsDecode,
    input  logic [REG_W-1:0] rtDecode,
    input  logic             useRsDecode,
    input  logic             useRtDecode,
    input  logic             branchTakenD,
    output logic             stall,
    output logic             pcWriteEn,
    output logic             ifIdWriteEn,
    output logic             ifIdFlush,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    // One-hot encoding: the two unused codes are illegal and fall back to RUN.
    typedef enum logic [1:0] {
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    localparam logic [3:0]       WAIT_LOAD = 4'(MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state, state_nxt;
    logic [3:0] waitCnt, waitCnt_nxt;
    logic       loadUse;

    // A load to r0 never creates a dependency; an instruction matching on
    // both sources still yields a single hazard.
    assign loadUse = MemReadEnExecute && (rtExecute != '0) &&
                     ((useRsDecode && (rsDecode == rtExecute)) ||
                      (useRtDecode && (rtDecode == rtExecute)));

    // State register and counters
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            waitCnt    <= '0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state   <= state_nxt;
            waitCnt <= waitCnt_nxt;
            if (stall && (stallCount != CNT_MAX)) begin
                stallCount <= stallCount + 1'b1;
            end
            if (ifIdFlush && (flushCount != CNT_MAX)) begin
                flushCount <= flushCount + 1'b1;
            end
        end
    end

    // Next-state logic
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        waitCnt_nxt = waitCnt;
        case (state)
            ST_RUN: begin
                // With MEM_WAIT=0 the single RUN stall cycle is the whole stall.
                if (loadUse && (WAIT_LOAD != 4'd0)) begin
                    state_nxt   = ST_WAIT;
                    waitCnt_nxt = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                // Inputs are ignored here: EX holds a bubble, decode is frozen.
                // A count of 0 can only come from corruption; leave as well.
                if (waitCnt <= 4'd1) begin
                    state_nxt   = ST_RUN;
                    waitCnt_nxt = '0;
                end else begin
                    waitCnt_nxt = waitCnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = ST_RUN;
                waitCnt_nxt = '0;
            end
        endcase
    end

    // Mealy outputs: the hazard is resolved in the cycle it is seen.
    always_comb begin
        stall       = 1'b0;
        pcWriteEn   = 1'b1;
        ifIdWriteEn = 1'b1;
        ifIdFlush   = 1'b0;
        if (!reset) begin
            pcWriteEn   = 1'b0;
            ifIdWriteEn = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (loadUse) begin
                        // A stalled branch re-resolves later with valid operands,
                        // so branchTakenD must not squash IF/ID here.
                        stall       = 1'b1;
                        pcWriteEn   = 1'b0;
                        ifIdWriteEn = 1'b0;
                    end else if (branchTakenD) begin
                        ifIdFlush = 1'b1;
                    end
                end
                ST_WAIT: begin
                    stall       = 1'b1;
                    pcWriteEn   = 1'b0;
                    ifIdWriteEn = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Four instances share one stimulus stream:
//     u0 MEM_WAIT=0 CNT_W=16, u1 MEM_WAIT=2 CNT_W=16,
//     u2 MEM_WAIT=3 CNT_W=16, u3 MEM_WAIT=0 CNT_W=4.
//   A behavioural model tracks, per instance, how many forced stall cycles
//   remain after the current one plus the two counters, and predicts every
//   output each cycle. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       MemReadEnExecute;
    logic [4:0] rtExecute, rsDecode, rtDecode;
    logic       useRsDecode, useRtDecode, branchTakenD;

    logic [N-1:0] st_v, pc_v, ifw_v, fl_v;
    logic [15:0]  sc0, sc1, sc2, fc0, fc1, fc2;
    logic [3:0]   sc3, fc3;

    int checks = 0;
    int errors = 0;

    // Model state
    int wait_left [N];
    int scnt [N];
    int fcnt [N];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .MEM_WAIT(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .MemReadEnExecute(MemReadEnExecute),
        .rtExecute(rtExecute), .rsDecode(rsDecode), .rtDecode(rtDecode),
        .useRsDecode(useRsDecode), .useRtDecode(useRtDecode), .branchTakenD(branchTakenD),
        .stall(st_v[0]), .pcWriteEn(pc_v[0]), .ifIdWriteEn(ifw_v[0]), .ifIdFlush(fl_v[0]),
        .stallCount(sc0), .flushCount(fc0));

    hazard_stall_ctrl #(.REG_W(5), .MEM_WAIT(2), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .MemReadEnExecute(MemReadEnExecute),
        .rtExecute(rtExecute), .rsDecode(rsDecode), .rtDecode(rtDecode),
        .useRsDecode(useRsDecode), .useRtDecode(useRtDecode), .branchTakenD(branchTakenD),
        .stall(st_v[1]), .pcWriteEn(pc_v[1]), .ifIdWriteEn(ifw_v[1]), .ifIdFlush(fl_v[1]),
        .stallCount(sc1), .flushCount(fc1));

    hazard_stall_ctrl #(.REG_W(5), .MEM_WAIT(3), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .MemReadEnExecute(MemReadEnExecute),
        .rtExecute(rtExecute), .rsDecode(rsDecode), .rtDecode(rtDecode),
        .useRsDecode(useRsDecode), .useRtDecode(useRtDecode), .branchTakenD(branchTakenD),
        .stall(st_v[2]), .pcWriteEn(pc_v[2]), .ifIdWriteEn(ifw_v[2]), .ifIdFlush(fl_v[2]),
        .stallCount(sc2), .flushCount(fc2));

    hazard_stall_ctrl #(.REG_W(5), .MEM_WAIT(0), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .MemReadEnExecute(MemReadEnExecute),
        .rtExecute(rtExecute), .rsDecode(rsDecode), .rtDecode(rtDecode),
        .useRsDecode(useRsDecode), .useRtDecode(useRtDecode), .branchTakenD(branchTakenD),
        .stall(st_v[3]), .pcWriteEn(pc_v[3]), .ifIdWriteEn(ifw_v[3]), .ifIdFlush(fl_v[3]),
        .stallCount(sc3), .flushCount(fc3));

    function automatic int mem_wait(input int i);
        case (i)
            1:       return 2;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 3) ? 15 : 65535;
    endfunction

    function automatic int obs_scnt(input int i);
        case (i)
            0:       return int'(sc0);
            1:       return int'(sc1);
            2:       return int'(sc2);
            default: return int'(sc3);
        endcase
    endfunction

    function automatic int obs_fcnt(input int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            2:       return int'(fc2);
            default: return int'(fc3);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            wait_left[i] = 0;
            scnt[i]      = 0;
            fcnt[i]      = 0;
        end
    endtask

    task automatic set_idle();
        MemReadEnExecute = 1'b0;
        rtExecute        = '0;
        rsDecode         = '0;
        rtDecode         = '0;
        useRsDecode      = 1'b0;
        useRtDecode      = 1'b0;
        branchTakenD     = 1'b0;
    endtask

    // Load rd in EX with decode reading it through rs (sel=0) or rt (sel=1).
    task automatic set_hazard(input logic [4:0] rd, input bit sel);
        set_idle();
        MemReadEnExecute = 1'b1;
        rtExecute        = rd;
        if (sel) begin
            rtDecode    = rd;
            useRtDecode = 1'b1;
        end else begin
            rsDecode    = rd;
            useRsDecode = 1'b1;
        end
    endtask

    // Called at posedge+1 with inputs set: check all outputs at the negedge
    // against the model, advance the model, and return at the next posedge+1.
    task automatic step(input string tag);
        bit lu;
        bit es, ep, ef;
        @(negedge clk);
        lu = MemReadEnExecute && (rtExecute != 0) &&
             ((useRsDecode && (rsDecode == rtExecute)) ||
              (useRtDecode && (rtDecode == rtExecute)));
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                es = 0; ep = 0; ef = 0;
            end else if (wait_left[i] > 0) begin
                es = 1; ep = 0; ef = 0;
            end else begin
                es = lu;
                ep = !lu;
                ef = !lu && branchTakenD;
            end
            check($sformatf("%s_u%0d_stall", tag, i), 32'(st_v[i]), 32'(es));
            check($sformatf("%s_u%0d_pcwe", tag, i), 32'(pc_v[i]), 32'(ep));
            check($sformatf("%s_u%0d_ifidwe", tag, i), 32'(ifw_v[i]), 32'(ep));
            check($sformatf("%s_u%0d_flush", tag, i), 32'(fl_v[i]), 32'(ef));
            check($sformatf("%s_u%0d_scnt", tag, i), 32'(obs_scnt(i)), 32'(scnt[i]));
            check($sformatf("%s_u%0d_fcnt", tag, i), 32'(obs_fcnt(i)), 32'(fcnt[i]));
            if (reset) begin
                if (es && scnt[i] < cnt_max(i)) scnt[i]++;
                if (ef && fcnt[i] < cnt_max(i)) fcnt[i]++;
                if (wait_left[i] > 0) wait_left[i]--;
                else if (lu) wait_left[i] = mem_wait(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: assert reset mid-cycle, check that outputs and
    // counters clear at once, hold across one edge, release at posedge+1.
    task automatic pulse_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        check({tag, "_stall"}, 32'(st_v), 32'd0);
        check({tag, "_pcwe"}, 32'(pc_v), 32'd0);
        check({tag, "_ifidwe"}, 32'(ifw_v), 32'd0);
        check({tag, "_flush"}, 32'(fl_v), 32'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_u%0d_scnt", tag, i), 32'(obs_scnt(i)), 32'd0);
            check($sformatf("%s_u%0d_fcnt", tag, i), 32'(obs_fcnt(i)), 32'd0);
        end
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        set_hazard(5'd5, 1'b0);
        model_clear();
        #1;
        // Reset state: outputs forced low even with a live hazard on the inputs.
        check("rst_stall", 32'(st_v), 32'd0);
        check("rst_pcwe", 32'(pc_v), 32'd0);
        check("rst_flush", 32'(fl_v), 32'd0);
        check("rst_scnt0", sc0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_idle();
        step("idle0");

        // T1: one-cycle stall for MEM_WAIT=0
        set_hazard(5'd5, 1'b0);
        step("t1_hz");
        check("t1_scnt", sc0, 32'd1);
        set_idle();
        step("t1_after");
        check("t1_scnt_hold", sc0, 32'd1);

        // T2: load to r0, and a matching rs that is not used
        pulse_reset("t2_rst");
        set_hazard(5'd0, 1'b0);
        step("t2_r0");
        set_hazard(5'd5, 1'b0);
        useRsDecode = 1'b0;
        step("t2_nouse");
        check("t2_scnt", sc0, 32'd0);

        // T3: MEM_WAIT=2 stalls 3 cycles; branches during the stall ignored
        pulse_reset("t3_rst");
        set_hazard(5'd7, 1'b1);
        step("t3_hz");
        for (int k = 0; k < 2; k++) begin
            set_idle();
            branchTakenD = 1'($urandom_range(0, 1));
            step("t3_wait");
        end
        check("t3_scnt", sc1, 32'd3);
        check("t3_fcnt", fc1, 32'd0);
        set_idle();
        step("t3_run");
        check("t3_scnt_hold", sc1, 32'd3);

        // T4: flush without hazard; hazard wins over branch
        pulse_reset("t4_rst");
        set_idle();
        branchTakenD = 1'b1;
        step("t4_br");
        check("t4_fcnt", fc0, 32'd1);
        check("t4_scnt", sc0, 32'd0);
        set_hazard(5'd9, 1'b0);
        branchTakenD = 1'b1;
        step("t4_br_hz");
        check("t4_fcnt_hold", fc0, 32'd1);
        check("t4_scnt_hz", sc0, 32'd1);

        // T5: reset during the 2nd WAIT cycle of MEM_WAIT=3
        pulse_reset("t5_pre");
        set_hazard(5'd3, 1'b0);
        step("t5_hz");
        set_idle();
        step("t5_wait1");
        pulse_reset("t5_rst");
        step("t5_after");
        check("t5_stall_u2", 32'(st_v[2]), 32'd0);
        check("t5_scnt_u2", sc2, 32'd0);

        // T6: 20 stall cycles saturate a 4-bit counter at 15
        pulse_reset("t6_rst");
        set_hazard(5'd4, 1'b1);
        for (int k = 0; k < 20; k++) step("t6_hz");
        check("t6_sat_u3", 32'(sc3), 32'd15);
        check("t6_cnt_u0", sc0, 32'd20);
        set_idle();
        step("t6_after");

        // Random traffic with narrow register ranges to provoke matches
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 63) == 0) pulse_reset("rnd_rst");
            MemReadEnExecute = 1'($urandom_range(0, 1));
            rtExecute        = 5'($urandom_range(0, 3));
            rsDecode         = 5'($urandom_range(0, 3));
            rtDecode         = 5'($urandom_range(0, 3));
            useRsDecode      = 1'($urandom_range(0, 1));
            useRtDecode      = 1'($urandom_range(0, 1));
            branchTakenD     = 1'($urandom_range(0, 1));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
